// File: rtl/id_regfile_sb_if.sv
// Decode-stage register file bus: read ports, issue handshake, writeback and scoreboard status.
// The master side drives decode and writeback; the slave side is the register file.
interface id_regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NRD    = 2
);
    logic                  id_valid;
    logic                  flush;
    logic [NRD*AW-1:0]     ra;
    logic [NRD-1:0]        ra_used;
    logic [NRD*DATA_W-1:0] rd;
    logic [AW-1:0]         wa_d;
    logic                  wrf_d;
    logic                  long_d;
    logic                  id_ready;
    logic                  issue;
    logic                  wb_wena;
    logic [AW-1:0]         wb_wa;
    logic [DATA_W-1:0]     wb_wd;
    logic                  wb_long;
    logic [NREG-1:0]       busy_vec;
    logic                  sb_err;
    logic [31:0]           stall_cnt;

    modport master (
        output id_valid, flush, ra, ra_used, wa_d, wrf_d, long_d,
        output wb_wena, wb_wa, wb_wd, wb_long,
        input  rd, id_ready, issue, busy_vec, sb_err, stall_cnt
    );

    modport slave (
        input  id_valid, flush, ra, ra_used, wa_d, wrf_d, long_d,
        input  wb_wena, wb_wa, wb_wd, wb_long,
        output rd, id_ready, issue, busy_vec, sb_err, stall_cnt
    );
endinterface

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with writeback bypass, per-register long-latency scoreboard
// and issue/stall handshake. Define SB_STATS_EN to build the saturating stall cycle counter.
module id_regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned PEND_W = 2
) (
    input logic            clk,
    input logic            rst,
    id_regfile_sb_if.slave bus
);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0]     regs_q [NREG];
    logic [PEND_W-1:0]     pend_q [NREG];
    logic [PEND_W-1:0]     pend_d [NREG];
    logic                  sb_err_q;
    logic                  sb_err_d;

    logic [NRD*DATA_W-1:0] rd_int;
    logic [NRD-1:0]        src_hz;
    logic                  waw_hz;
    logic                  sat_hz;
    logic                  id_ready;
    logic                  issue;
    logic                  wb_done;
    logic                  inc;
    logic                  dec;
    logic [NREG-1:0]       busy_vec;

    // A long writeback completing this cycle is bypassed, so it retires its hazard now.
    assign wb_done = bus.wb_wena & bus.wb_long;

    always_comb begin
        rd_int = '0;
        src_hz = '0;
        for (int k = 0; k < int'(NRD); k++) begin
            logic [AW-1:0] ra_k;
            ra_k = bus.ra[k*AW +: AW];
            if (bus.wb_wena && bus.wb_wa == ra_k && ra_k != '0) begin
                rd_int[k*DATA_W +: DATA_W] = bus.wb_wd;
            end else begin
                rd_int[k*DATA_W +: DATA_W] = regs_q[ra_k];
            end
            src_hz[k] = bus.ra_used[k] && pend_q[ra_k] != '0 &&
                        !(pend_q[ra_k] == PEND_ONE && wb_done && bus.wb_wa == ra_k);
        end
    end

    always_comb begin
        waw_hz = bus.wrf_d && bus.wa_d != '0 && pend_q[bus.wa_d] != '0 && !bus.long_d &&
                 !(pend_q[bus.wa_d] == PEND_ONE && wb_done && bus.wb_wa == bus.wa_d);
        sat_hz = bus.wrf_d && bus.long_d && bus.wa_d != '0 && pend_q[bus.wa_d] == PEND_MAX;
        id_ready = !((|src_hz) || waw_hz || sat_hz);
        issue    = bus.id_valid && id_ready && !bus.flush;
        inc      = issue && bus.wrf_d && bus.long_d && bus.wa_d != '0;
        dec      = wb_done && bus.wb_wa != '0;
    end

    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < int'(NREG); r++) begin
            logic inc_r;
            logic dec_r;
            pend_d[r] = pend_q[r];
            inc_r = inc && bus.wa_d == AW'(r);
            dec_r = dec && bus.wb_wa == AW'(r);
            if (r != 0) begin
                if (inc_r && !dec_r) begin
                    pend_d[r] = pend_q[r] + PEND_ONE;
                end else if (dec_r && !inc_r) begin
                    if (pend_q[r] == '0) begin
                        sb_err_d = 1'b1;
                    end else begin
                        pend_d[r] = pend_q[r] - PEND_ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < int'(NREG); r++) begin
            busy_vec[r] = pend_q[r] != '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (bus.wb_wena && bus.wb_wa != '0) begin
                regs_q[bus.wb_wa] <= bus.wb_wd;
            end
            for (int r = 0; r < int'(NREG); r++) begin
                pend_q[r] <= pend_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

`ifdef SB_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (bus.id_valid && !bus.flush && !id_ready && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

    assign bus.rd       = rd_int;
    assign bus.id_ready = id_ready;
    assign bus.issue    = issue;
    assign bus.busy_vec = busy_vec;
    assign bus.sb_err   = sb_err_q;
endmodule

// File: doc/id_regfile_sb.md
Name: id_regfile_sb

Overview:
- Parametrised decode-stage register file with N read ports and write-to-read bypass from writeback.
- Per-register scoreboard tracks outstanding long-latency writes (mult/div, mfc0/mfhi/mflo result paths, loads).
- Generates the decode-stage issue/stall handshake.
- Successor to the fixed two-port regfile inside the ID stage; sits between fetch/decode and execute.

Parameters:
DATA_W, 32, register data width
NREG, 32, number of architectural registers (power of 2)
AW, 5, register address width, log2(NREG)
NRD, 2, number of read ports (1..4)
PEND_W, 2, width of per-register outstanding-write counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
id_valid  in  1  decode stage holds a valid instruction
flush  in  1  kill current decode instruction
ra  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
ra_used  in  NRD  port k source actually needed by instruction
rd  out  NRD*DATA_W  packed read data
wa_d  in  AW  destination of decoding instruction
wrf_d  in  1  decoding instruction writes a register
long_d  in  1  destination result arrives via long-latency path
id_ready  out  1  no hazard; instruction may issue
issue  out  1  id_valid & id_ready & ~flush
wb_wena  in  1  writeback write enable
wb_wa  in  AW  writeback address
wb_wd  in  DATA_W  writeback data
wb_long  in  1  this writeback completes a long-latency op
busy_vec  out  NREG  bit r = pend[r] != 0
sb_err  out  1  sticky scoreboard underflow flag
stall_cnt  out  32  stall cycle counter (see Optional Feature)

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-low.
- While rst=0: all registers = 0, all pend counters = 0, sb_err = 0, stall_cnt = 0.
- Outputs during reset: busy_vec = 0, id_ready = 1, issue = id_valid & ~flush.
- Register 0 reads 0, ignores writes, is never busy, and its counter never changes.
- Reads are combinational.
  - If wb_wena, wb_wa == ra[k], and ra[k] != 0, then rd[k] = wb_wd (bypass).
  - Otherwise rd[k] = the stored value.
- Register write happens at posedge when wb_wena=1 and wb_wa != 0.
- src_hz[k] = ra_used[k] & pend[ra[k]] != 0.
  - src_hz[k] is cleared if pend == 1 and wb_wena & wb_long & wb_wa == ra[k] in the same cycle (completing write is bypassed).
- waw_hz = wrf_d & wa_d != 0 & pend[wa_d] != 0 & ~long_d. A short write must not be overtaken by an older long write.
  - The same completion exemption as src_hz applies.
- sat_hz = wrf_d & long_d & wa_d != 0 & pend[wa_d] == 2^PEND_W - 1.
- id_ready = ~(any src_hz | waw_hz | sat_hz). id_ready depends only on current inputs and state; there are no registered stalls.
- Counter update at posedge:
  - inc = issue & wrf_d & long_d & wa_d != 0.
  - dec = wb_wena & wb_long & wb_wa != 0.
  - Same register with both inc and dec: counter unchanged.
  - dec on a counter at 0: counter stays 0 and sb_err is set (sticky until reset).
- flush=1 forces issue=0, so the scoreboard is not incremented. Already-issued long ops still write back and decrement.
- Reset asserted mid-operation clears all scoreboard state immediately. Writebacks arriving after reset deassertion with wb_long=1 set sb_err; the pipeline is flushed on reset, so this case is an error.

Optional Feature:
- Macro: SB_STATS_EN.
- Defined: stall_cnt increments each cycle id_valid & ~flush & ~id_ready. It saturates at 0xFFFFFFFF and is cleared only by reset.
- Undefined: stall_cnt is constant 0 and no counter logic is built.

Test Plan:
- Reset, then write r5 = 0x1234_5678 and read ra[0] = 5 the next cycle -> rd[0] = 0x12345678. Write r0 = 0xFFFF_FFFF -> rd = 0.
- Same-cycle bypass: wb_wena=1, wb_wa=7, wb_wd=0xA5A5_0000 with ra[1]=7 -> rd[1] = 0xA5A50000 combinationally, before the clock edge.
- Issue long op to r3 (id_valid, wrf_d, long_d, wa_d=3) -> busy_vec[3]=1. Next instr with ra[0]=3, ra_used=01 -> id_ready=0, issue=0. Assert wb_long, wb_wa=3 -> id_ready=1 that cycle, rd[0] = wb_wd. busy_vec[3]=0 after the edge.
- PEND_W=2: issue three long ops to r9 -> pend=3. Fourth long issue to r9 -> id_ready=0 (sat_hz). A short write to r9 is also stalled (waw_hz).
- Simultaneous issue of a long op to r4 and wb_long completion to r4 with pend=1 -> pend stays 1. flush=1 with a hazard-free long op -> issue=0, pend unchanged.
- wb_long to r12 with pend=0 -> sb_err=1 and it stays set. With SB_STATS_EN defined, 10 stalled cycles -> stall_cnt=10. With it undefined -> stall_cnt=0.
